wb_hilo_multi: RTL and testbench

Parametrised multi-lane writeback stage for the MIPS pipeline. It accepts one bundle of up to LANES retiring instructions per cycle from the memory stage and selects each lane's result. It owns the architectural HI/LO registers, forwarding HI/LO in program order within a bundle. It drives the register-file write ports from a registered W-stage and suppresses younger lanes behind an excepting lane.

---
 rtl/wb_hilo_multi_if.sv | 35 +++
 rtl/wb_hilo_multi.sv | 128 ++++++++++++
 tb/tb_wb_hilo_multi.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_hilo_multi_if.sv
// Memory-to-writeback bundle: per-lane retiring instructions plus the stage
// controls (stall/flush) and the ready handshake back to the memory stage.
interface wb_hilo_multi_if #(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  logic [LANES-1:0]      m_valid;
  logic [LANES-1:0]      m_wen;
  logic [LANES*AW-1:0]   m_rd;
  logic [LANES*3-1:0]    m_sel;
  logic [LANES*2-1:0]    m_hilo_op;
  logic [LANES*DW-1:0]   m_alu;
  logic [LANES*DW-1:0]   m_mem;
  logic [LANES*DW-1:0]   m_cp0;
  logic [LANES*2*DW-1:0] m_prod;
  logic [LANES-1:0]      m_exc;
  logic                  stall;
  logic                  flush;
  logic                  m_ready;

  modport master (
    output m_valid, m_wen, m_rd, m_sel, m_hilo_op,
    output m_alu, m_mem, m_cp0, m_prod, m_exc,
    output stall, flush,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_wen, m_rd, m_sel, m_hilo_op,
    input  m_alu, m_mem, m_cp0, m_prod, m_exc,
    input  stall, flush,
    output m_ready
  );
endinterface

// File: rtl/wb_hilo_multi.sv
// Multi-lane MIPS writeback stage: per-lane result select, in-order HI/LO
// forwarding across the bundle, exception kill of younger lanes, registered W-stage.
module wb_hilo_multi #(
  parameter  int LANES = 2,
  parameter  int DW    = 32,
  parameter  int AW    = 5,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  wb_hilo_multi_if.slave      m,
  output logic [LANES-1:0]    rf_wen,
  output logic [LANES*AW-1:0] rf_waddr,
  output logic [LANES*DW-1:0] rf_wdata,
  output logic [DW-1:0]       hi,
  output logic [DW-1:0]       lo,
  output logic                exc_out,
  output logic [LW-1:0]       exc_lane
);

  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_HI  = 3'd2;
  localparam logic [2:0] SEL_LO  = 3'd3;
  localparam logic [2:0] SEL_CP0 = 3'd4;

  localparam logic [1:0] OP_HI   = 2'd1;
  localparam logic [1:0] OP_LO   = 2'd2;
  localparam logic [1:0] OP_PROD = 2'd3;

  logic [DW-1:0]       hi_p0;
  logic [DW-1:0]       lo_p0;
  logic [LANES-1:0]    live_p0;
  logic [LANES-1:0]    wr_p0;
  logic [LANES-1:0]    wen_p0;
  logic [LANES*DW-1:0] res_p0;
  logic                any_exc_p0;
  logic [LW-1:0]       exc_idx_p0;
  logic                killed_p0;

  assign m.m_ready = ~m.stall;

  // Stage p0: combinational bundle evaluation, lanes walked oldest first
  always_comb begin
    hi_p0      = hi;
    lo_p0      = lo;
    live_p0    = '0;
    wr_p0      = '0;
    res_p0     = '0;
    killed_p0  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (m.m_exc[k]) killed_p0 = 1'b1;
      live_p0[k] = m.m_valid[k] & ~killed_p0;

      // Lane k observes HI/LO as left by all older live lanes
      unique case (m.m_sel[k*3 +: 3])
        SEL_MEM: res_p0[k*DW +: DW] = m.m_mem[k*DW +: DW];
        SEL_HI:  res_p0[k*DW +: DW] = hi_p0;
        SEL_LO:  res_p0[k*DW +: DW] = lo_p0;
        SEL_CP0: res_p0[k*DW +: DW] = m.m_cp0[k*DW +: DW];
        default: res_p0[k*DW +: DW] = m.m_alu[k*DW +: DW];
      endcase

      wr_p0[k] = live_p0[k] & m.m_wen[k] & (m.m_rd[k*AW +: AW] != '0);

      if (live_p0[k]) begin
        unique case (m.m_hilo_op[k*2 +: 2])
          OP_HI:   hi_p0 = m.m_alu[k*DW +: DW];
          OP_LO:   lo_p0 = m.m_alu[k*DW +: DW];
          OP_PROD: begin
            hi_p0 = m.m_prod[k*2*DW + DW +: DW];
            lo_p0 = m.m_prod[k*2*DW +: DW];
          end
          default: ;
        endcase
      end
    end
  end

  // An older lane is dropped when a younger live lane writes the same register
  always_comb begin
    wen_p0 = wr_p0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = k + 1; j < LANES; j++) begin
        if (wr_p0[j] && (m.m_rd[j*AW +: AW] == m.m_rd[k*AW +: AW]))
          wen_p0[k] = 1'b0;
      end
    end
  end

  // Oldest excepting lane; descending scan leaves the lowest index
  always_comb begin
    any_exc_p0 = 1'b0;
    exc_idx_p0 = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m.m_valid[k] && m.m_exc[k]) begin
        any_exc_p0 = 1'b1;
        exc_idx_p0 = LW'(k);
      end
    end
  end

  // Stage p1: registered W-stage and architectural HI/LO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_wen   <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi       <= '0;
      lo       <= '0;
      exc_out  <= 1'b0;
      exc_lane <= '0;
    end else if (!m.stall) begin
      if (m.flush) begin
        rf_wen  <= '0;
        exc_out <= 1'b0;
      end else begin
        rf_wen   <= wen_p0;
        rf_waddr <= m.m_rd;
        rf_wdata <= res_p0;
        hi       <= hi_p0;
        lo       <= lo_p0;
        exc_out  <= any_exc_p0;
        exc_lane <= exc_idx_p0;
      end
    end
  end

endmodule

// File: tb/tb_wb_hilo_multi.sv
// Self-checking bench for wb_hilo_multi: directed scenarios plus randomized
// bundles compared against a lane-level behavioural model.
module tb_wb_hilo_multi;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LW = 1;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_hilo_multi_if #(.LANES(L), .DW(DW), .AW(AW)) bus ();

  logic [L-1:0]    rf_wen;
  logic [L*AW-1:0] rf_waddr;
  logic [L*DW-1:0] rf_wdata;
  logic [DW-1:0]   hi, lo;
  logic            exc_out;
  logic [LW-1:0]   exc_lane;

  wb_hilo_multi #(.LANES(L), .DW(DW), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .m(bus),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi(hi), .lo(lo), .exc_out(exc_out), .exc_lane(exc_lane)
  );

  // Stimulus, one entry per lane
  logic [L-1:0]    s_valid, s_wen, s_exc;
  logic [AW-1:0]   s_rd   [L];
  logic [2:0]      s_sel  [L];
  logic [1:0]      s_op   [L];
  logic [DW-1:0]   s_alu  [L];
  logic [DW-1:0]   s_mem  [L];
  logic [DW-1:0]   s_cp0  [L];
  logic [2*DW-1:0] s_prod [L];
  logic            s_stall, s_flush;

  // Reference model state
  logic [DW-1:0] m_hi, m_lo;
  logic [L-1:0]  e_wen;
  logic [AW-1:0] e_waddr [L];
  logic [DW-1:0] e_wdata [L];
  logic          e_exc;
  logic [LW-1:0] e_lane;

  int checks = 0;
  int passed = 0;

  task automatic clear_stim();
    s_valid = '0; s_wen = '0; s_exc = '0; s_stall = 1'b0; s_flush = 1'b0;
    for (int k = 0; k < L; k++) begin
      s_rd[k] = '0; s_sel[k] = '0; s_op[k] = '0;
      s_alu[k] = '0; s_mem[k] = '0; s_cp0[k] = '0; s_prod[k] = '0;
    end
  endtask

  task automatic drive();
    bus.m_valid = s_valid; bus.m_wen = s_wen; bus.m_exc = s_exc;
    bus.stall = s_stall; bus.flush = s_flush;
    for (int k = 0; k < L; k++) begin
      bus.m_rd[k*AW +: AW]       = s_rd[k];
      bus.m_sel[k*3 +: 3]        = s_sel[k];
      bus.m_hilo_op[k*2 +: 2]    = s_op[k];
      bus.m_alu[k*DW +: DW]      = s_alu[k];
      bus.m_mem[k*DW +: DW]      = s_mem[k];
      bus.m_cp0[k*DW +: DW]      = s_cp0[k];
      bus.m_prod[k*2*DW +: 2*DW] = s_prod[k];
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; e_wen = '0; e_exc = 1'b0; e_lane = '0;
    for (int k = 0; k < L; k++) begin e_waddr[k] = '0; e_wdata[k] = '0; end
  endtask

  // What the stage should present after the coming edge
  task automatic model_edge();
    int first_exc;
    int owner [NR];
    logic [DW-1:0] h, l;
    logic [L-1:0] writes;
    logic found;
    if (s_stall) return;
    if (s_flush) begin e_wen = '0; e_exc = 1'b0; return; end
    first_exc = L;
    for (int k = L - 1; k >= 0; k--) if (s_exc[k]) first_exc = k;
    h = m_hi; l = m_lo; writes = '0;
    for (int r = 0; r < NR; r++) owner[r] = -1;
    for (int k = 0; k < L; k++) begin
      bit live;
      live = s_valid[k] && (k < first_exc);
      case (s_sel[k])
        3'd1: e_wdata[k] = s_mem[k];
        3'd2: e_wdata[k] = h;
        3'd3: e_wdata[k] = l;
        3'd4: e_wdata[k] = s_cp0[k];
        default: e_wdata[k] = s_alu[k];
      endcase
      e_waddr[k] = s_rd[k];
      if (live && s_op[k] == 2'd1) h = s_alu[k];
      if (live && s_op[k] == 2'd2) l = s_alu[k];
      if (live && s_op[k] == 2'd3) begin h = s_prod[k][2*DW-1:DW]; l = s_prod[k][DW-1:0]; end
      writes[k] = live && s_wen[k] && (s_rd[k] != 0);
      if (writes[k]) owner[s_rd[k]] = k;
    end
    for (int k = 0; k < L; k++) e_wen[k] = writes[k] && (owner[s_rd[k]] == k);
    m_hi = h; m_lo = l;
    e_exc = 1'b0; e_lane = '0; found = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (!found && s_valid[k] && s_exc[k]) begin
        found = 1'b1; e_exc = 1'b1; e_lane = LW'(k);
      end
    end
  endtask

  task automatic cycle();
    drive();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_stim();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, hi, lo, exc_out, exc_lane} !== '0)
      $display("FAIL reset_state: wen=%b waddr=%h wdata=%h hi=%h lo=%h exc=%b lane=%b want all zero",
               rf_wen, rf_waddr, rf_wdata, hi, lo, exc_out, exc_lane);
    else passed++;
    checks++;
    if (bus.m_ready !== 1'b1) $display("FAIL ready_idle: got %b want 1", bus.m_ready);
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    clear_stim();
    s_valid = 2'b11;
    s_op[0] = 2'd3; s_prod[0] = {32'h1, 32'h2};
    s_wen[1] = 1'b1; s_sel[1] = 3'd2; s_rd[1] = 5'd8;
    cycle();
    checks++;
    if (rf_wen !== 2'b10) $display("FAIL fwd_wen: got %b want 10", rf_wen); else passed++;
    checks++;
    if ({rf_waddr[2*AW-1:AW], rf_wdata[2*DW-1:DW]} !== {5'd8, 32'h1})
      $display("FAIL fwd_lane1: got rd=%0d data=%h want rd=8 data=1", rf_waddr[2*AW-1:AW], rf_wdata[2*DW-1:DW]);
    else passed++;
    checks++;
    if ({hi, lo} !== {32'h1, 32'h2}) $display("FAIL fwd_hilo: got %h/%h want 1/2", hi, lo); else passed++;
  endtask

  task automatic test_exc_kill();
    clear_stim();
    s_valid = 2'b11;
    s_wen[0] = 1'b1; s_rd[0] = 5'd4; s_alu[0] = 32'd7;
    s_exc[1] = 1'b1; s_op[1] = 2'd1; s_alu[1] = 32'd99; s_wen[1] = 1'b1; s_rd[1] = 5'd5;
    cycle();
    checks++;
    if (rf_wen !== 2'b01) $display("FAIL exc_wen: got %b want 01", rf_wen); else passed++;
    checks++;
    if (hi !== 32'h1) $display("FAIL exc_hi: got %h want 1", hi); else passed++;
    checks++;
    if ({exc_out, exc_lane} !== 2'b11) $display("FAIL exc_flag: got exc=%b lane=%b want 1/1", exc_out, exc_lane);
    else passed++;
    clear_stim();
    cycle();
    checks++;
    if ({rf_wen, exc_out} !== 3'b000) $display("FAIL exc_pulse: got wen=%b exc=%b want 00/0", rf_wen, exc_out);
    else passed++;
  endtask

  task automatic test_same_rd();
    clear_stim();
    s_valid = 2'b11; s_wen = 2'b11;
    s_rd[0] = 5'd3; s_alu[0] = 32'd10;
    s_rd[1] = 5'd3; s_alu[1] = 32'd20;
    cycle();
    checks++;
    if (rf_wen !== 2'b10) $display("FAIL same_rd_wen: got %b want 10", rf_wen); else passed++;
    checks++;
    if (rf_wdata[2*DW-1:DW] !== 32'd20) $display("FAIL same_rd_data: got %0d want 20", rf_wdata[2*DW-1:DW]);
    else passed++;
  endtask

  task automatic test_zero_rd();
    clear_stim();
    s_valid = 2'b11; s_wen = 2'b11;
    s_rd[0] = 5'd0; s_rd[1] = 5'd6;
    cycle();
    checks++;
    if (rf_wen !== 2'b10) $display("FAIL zero_rd_l0: got %b want 10", rf_wen); else passed++;
    s_rd[0] = 5'd6; s_rd[1] = 5'd0;
    cycle();
    checks++;
    if (rf_wen !== 2'b01) $display("FAIL zero_rd_l1: got %b want 01", rf_wen); else passed++;
  endtask

  task automatic test_stall_flush();
    logic [L*DW-1:0] held;
    clear_stim();
    s_valid = 2'b11; s_wen = 2'b11;
    s_rd[0] = 5'd9;  s_op[0] = 2'd1; s_alu[0] = 32'h55;
    s_rd[1] = 5'd10; s_op[1] = 2'd2; s_alu[1] = 32'h66;
    cycle();
    held = rf_wdata;
    checks++;
    if ({rf_wen, hi, lo} !== {2'b11, 32'h55, 32'h66})
      $display("FAIL sf_setup: got wen=%b hi=%h lo=%h want 11/55/66", rf_wen, hi, lo);
    else passed++;
    s_stall = 1'b1; s_op[0] = 2'd3; s_prod[0] = {32'hdead, 32'hbeef}; s_alu[1] = 32'h77;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({rf_wen, rf_wdata, hi, lo, bus.m_ready} !== {2'b11, held, 32'h55, 32'h66, 1'b0})
        $display("FAIL stall_hold%0d: got wen=%b hi=%h lo=%h ready=%b want 11/55/66/0",
                 i, rf_wen, hi, lo, bus.m_ready);
      else passed++;
    end
    s_stall = 1'b0; s_flush = 1'b1;
    cycle();
    checks++;
    if ({rf_wen, exc_out, hi, lo} !== {2'b00, 1'b0, 32'h55, 32'h66})
      $display("FAIL flush: got wen=%b exc=%b hi=%h lo=%h want 00/0/55/66", rf_wen, exc_out, hi, lo);
    else passed++;
    s_flush = 1'b0; s_op[0] = 2'd0;
    cycle();
    s_stall = 1'b1; s_flush = 1'b1; s_op[0] = 2'd1; s_alu[0] = 32'h12;
    cycle();
    checks++;
    if ({rf_wen, hi} !== {2'b11, 32'h55})
      $display("FAIL stall_over_flush: got wen=%b hi=%h want 11/55", rf_wen, hi);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_stim();
    s_valid = 2'b11; s_wen = 2'b11;
    s_rd[0] = 5'd1; s_op[0] = 2'd1; s_alu[0] = 32'd5;
    s_rd[1] = 5'd2; s_alu[1] = 32'd9;
    cycle();
    checks++;
    if ({rf_wen, hi} !== {2'b11, 32'd5}) $display("FAIL rmid_setup: got wen=%b hi=%h want 11/5", rf_wen, hi);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, hi, lo, exc_out, exc_lane} !== '0)
      $display("FAIL rmid_async: wen=%b waddr=%h hi=%h lo=%h exc=%b want all zero",
               rf_wen, rf_waddr, hi, lo, exc_out);
    else passed++;
    model_reset();
    clear_stim();
    drive();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      s_stall = ($urandom_range(0, 5) == 0);
      s_flush = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < L; k++) begin
        s_valid[k] = ($urandom_range(0, 3) != 0);
        s_wen[k]   = ($urandom_range(0, 3) != 0);
        s_exc[k]   = ($urandom_range(0, 7) == 0);
        s_rd[k]    = AW'($urandom_range(0, 3));
        s_sel[k]   = 3'($urandom_range(0, 7));
        s_op[k]    = 2'($urandom_range(0, 3));
        s_alu[k]   = $urandom;
        s_mem[k]   = $urandom;
        s_cp0[k]   = $urandom;
        s_prod[k]  = {$urandom, $urandom};
      end
      cycle();
      checks++;
      if (rf_wen !== e_wen) $display("FAIL rnd_wen[%0d]: got %b want %b", n, rf_wen, e_wen);
      else passed++;
      for (int k = 0; k < L; k++) begin
        if (e_wen[k]) begin
          checks++;
          if ({rf_waddr[k*AW +: AW], rf_wdata[k*DW +: DW]} !== {e_waddr[k], e_wdata[k]})
            $display("FAIL rnd_lane%0d[%0d]: got rd=%0d data=%h want rd=%0d data=%h", k, n,
                     rf_waddr[k*AW +: AW], rf_wdata[k*DW +: DW], e_waddr[k], e_wdata[k]);
          else passed++;
        end
      end
      checks++;
      if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL rnd_hilo[%0d]: got %h/%h want %h/%h", n, hi, lo, m_hi, m_lo);
      else passed++;
      checks++;
      if (exc_out !== e_exc) $display("FAIL rnd_exc[%0d]: got %b want %b", n, exc_out, e_exc);
      else passed++;
      if (e_exc) begin
        checks++;
        if (exc_lane !== e_lane) $display("FAIL rnd_exc_lane[%0d]: got %0d want %0d", n, exc_lane, e_lane);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_exc_kill();
    test_same_rd();
    test_zero_rd();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
